// File: rtl/conv2_window_buf_pkg.sv
// Shared defaults for the conv2 window generator: pixel width, kernel size
// and the window element count derived from them.
package conv2_window_buf_pkg;

  localparam int DW_DEF = 12;
  localparam int K_DEF  = 5;

  function automatic int win_elems(input int k);
    return k * k;
  endfunction

  localparam int WIN_ELEMS = win_elems(K_DEF);

endpackage

// File: rtl/win_shift_line.sv
// Single-channel line shift register (K-1 lines plus K pixels) with the
// K x K tap mapping onto a packed window, element 0 = oldest top-left pixel.
module win_shift_line #(
  parameter int WIDTH = 12,
  parameter int K     = 5,
  parameter int DW    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic [DW-1:0]     din,
  output logic [K*K*DW-1:0] win
);

  localparam int D = WIDTH*(K-1) + K;

  logic [D-1:0][DW-1:0] sr_q, sr_d;

  // sr[0] is the newest pixel; every accepted pixel pushes the line one tap deeper
  always_comb begin
    sr_d = sr_q;
    if (shift_en) sr_d = {sr_q[D-2:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign win[DW*(r*K+c) +: DW] = sr_q[(K-1-r)*WIDTH + (K-1-c)];
    end
  end

endmodule

// File: rtl/conv2_window_buf.sv
// Streaming K x K window generator for three pool1 channels; counts raster
// position and strobes valid_out_buf only for windows fully inside the frame.
module conv2_window_buf
  import conv2_window_buf_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int HEIGHT = 12,
  parameter int K      = K_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           valid_in,
  input  logic [DW-1:0]                  data_in1,
  input  logic [DW-1:0]                  data_in2,
  input  logic [DW-1:0]                  data_in3,
  output logic [win_elems(K)*DW-1:0]     win1,
  output logic [win_elems(K)*DW-1:0]     win2,
  output logic [win_elems(K)*DW-1:0]     win3,
  output logic                           valid_out_buf,
  output logic                           frame_done
);

  localparam int NCH = 3;
  localparam int NE  = win_elems(K);
  localparam int CW  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [NCH-1:0][DW-1:0]    din;
  logic [NCH-1:0][NE*DW-1:0] win;

  assign din = {data_in3, data_in2, data_in1};

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    win_shift_line #(
      .WIDTH (WIDTH),
      .K     (K),
      .DW    (DW)
    ) u_line (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (valid_in),
      .din      (din[ch]),
      .win      (win[ch])
    );
  end

  assign win1 = win[0];
  assign win2 = win[1];
  assign win3 = win[2];

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          vld_q, vld_d;
  logic          done_q, done_d;
  logic          last_col, last_row;

  assign last_col = (col_q == CW'(WIDTH-1));
  assign last_row = (row_q == RW'(HEIGHT-1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    // col >= K-1 masks windows that would straddle a line edge
    vld_d  = valid_in && (row_q >= RW'(K-1)) && (col_q >= CW'(K-1));
    done_d = valid_in && last_row && last_col;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      vld_q  <= vld_d;
      done_q <= done_d;
    end
  end

  assign valid_out_buf = vld_q;
  assign frame_done    = done_q;

endmodule

// File: tb/tb_conv2_window_buf.sv
// Directed bench for conv2_window_buf: ramp frames, bubbles, back-to-back
// frames, mid-frame async reset and signed extremes.
module tb_conv2_window_buf;

  localparam int W  = 12;
  localparam int H  = 12;
  localparam int K  = 5;
  localparam int DW = 12;
  localparam int NE = K*K;

  logic              clk;
  logic              rst_n;
  logic              valid_in;
  logic [DW-1:0]     data_in1, data_in2, data_in3;
  logic [NE*DW-1:0]  win1, win2, win3;
  logic              valid_out_buf;
  logic              frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  conv2_window_buf #(.WIDTH(W), .HEIGHT(H), .K(K), .DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .data_in1      (data_in1),
    .data_in2      (data_in2),
    .data_in3      (data_in3),
    .win1          (win1),
    .win2          (win2),
    .win3          (win3),
    .valid_out_buf (valid_out_buf),
    .frame_done    (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int el(input logic [NE*DW-1:0] w, input int e);
    logic signed [DW-1:0] t;
    t = w[DW*e +: DW];
    return int'(t);
  endfunction

  // drive at negedge, sample 1 time unit after the accepting posedge
  task automatic px(input logic v, input int d1, input int d2, input int d3);
    @(negedge clk);
    valid_in = v;
    data_in1 = DW'(d1);
    data_in2 = DW'(d2);
    data_in3 = DW'(d3);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string nm, input int off, input bit bub, input bit ext);
    int strobes = 0;
    int dones   = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int p;
        bit exp_v;
        p = r*W + c;
        if (bub) begin
          px(1'b0, 0, 0, 0);
          chk({nm, "_bubble_nostrobe"}, int'(valid_out_buf), 0);
        end
        if (ext) px(1'b1, -2048, 2047, 0);
        else     px(1'b1, p+off, -(p+off), p+off+100);
        exp_v = (r >= K-1) && (c >= K-1);
        chk($sformatf("%s_strobe_r%0d_c%0d", nm, r, c), int'(valid_out_buf), int'(exp_v));
        chk($sformatf("%s_done_r%0d_c%0d", nm, r, c), int'(frame_done),
            int'(r == H-1 && c == W-1));
        if (valid_out_buf) strobes++;
        if (frame_done) dones++;
        if (exp_v && valid_out_buf) begin
          for (int e = 0; e < NE; e++) begin
            int rr, cc;
            rr = e / K;
            cc = e % K;
            if (ext) begin
              chk($sformatf("%s_w1_e%0d", nm, e), el(win1, e), -2048);
              chk($sformatf("%s_w2_e%0d", nm, e), el(win2, e), 2047);
            end else begin
              chk($sformatf("%s_w1_r%0d_c%0d_e%0d", nm, r, c, e), el(win1, e),
                  (r-K+1+rr)*W + (c-K+1+cc) + off);
            end
          end
          if (!ext) begin
            chk($sformatf("%s_w2_e24_r%0d_c%0d", nm, r, c), el(win2, NE-1), -(p+off));
            chk($sformatf("%s_w3_e0_r%0d_c%0d", nm, r, c), el(win3, 0),
                (r-K+1)*W + (c-K+1) + off + 100);
          end
        end
      end
    end
    chk({nm, "_strobe_count"}, strobes, (H-K+1)*(W-K+1));
    chk({nm, "_done_count"}, dones, 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in1 = '0;
    data_in2 = '0;
    data_in3 = '0;
    #12;
    chk("rst_valid", int'(valid_out_buf), 0);
    chk("rst_done",  int'(frame_done), 0);
    chk("rst_win1",  int'(|win1), 0);
    chk("rst_win2",  int'(|win2), 0);
    chk("rst_win3",  int'(|win3), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame("ramp", 0, 1'b0, 1'b0);
    run_frame("ramp2", 1000, 1'b0, 1'b0);
    run_frame("bub", 0, 1'b1, 1'b0);

    for (int p = 0; p < 70; p++) px(1'b1, p, -p, p+100);
    chk("pre_rst_valid", int'(valid_out_buf), 1);
    #2;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("midrst_valid", int'(valid_out_buf), 0);
    chk("midrst_done",  int'(frame_done), 0);
    chk("midrst_win1",  int'(|win1), 0);
    chk("midrst_win2",  int'(|win2), 0);
    chk("midrst_win3",  int'(|win3), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame("post_rst", 0, 1'b0, 1'b0);
    run_frame("ext", 0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv2_window_buf.md
Name: conv2_window_buf

Overview:
- Streaming 5x5 window generator that feeds the conv2 channel calculators.
- Accepts one pixel per cycle from each of 3 input channels (pool1 feature maps, raster order, 12-bit signed).
- Holds K-1 full lines plus K pixels per channel in a shift register and presents three packed 25-element windows with a valid strobe.
- Sits between the pool1 output stage and the conv2 calc units; it is the producer side of their window/valid_out_buf interface.

Parameters:
- WIDTH, 12, input feature-map width in pixels
- HEIGHT, 12, input feature-map height in pixels
- K, 5, kernel size (window is K x K)
- DW, 12, pixel width in bits (signed)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- valid_in  in  1  data_in1..3 carry a valid pixel this cycle
- data_in1  in  DW  channel 1 pixel, signed
- data_in2  in  DW  channel 2 pixel, signed
- data_in3  in  DW  channel 3 pixel, signed
- win1  out  K*K*DW  channel 1 window, packed
- win2  out  K*K*DW  channel 2 window, packed
- win3  out  K*K*DW  channel 3 window, packed
- valid_out_buf  out  1  windows valid this cycle
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all shift-register entries 0, row/col counters 0, valid_out_buf 0, frame_done 0. win1..3 therefore read 0.
- Storage: per channel, a shift register sr[0..D-1] with D = WIDTH*(K-1)+K (53 at defaults). sr[0] holds the newest pixel.
- Shift rule: on a clk edge with valid_in=1, sr[0] <= data_in and sr[i] <= sr[i-1]. With valid_in=0, everything holds.
- Window mapping: element e = r*K+c (r = row from top, c = column from left) occupies bits [DW*e+DW-1 : DW*e] and equals sr[(K-1-r)*WIDTH + (K-1-c)].
  - Element 0 is the top-left (oldest) pixel; element 24 is the newest pixel.
  - Windows are combinational from sr, so they are aligned with the registered valid.
- Counters: col in 0..WIDTH-1 and row in 0..HEIGHT-1 advance only on accepted pixels. col wraps at WIDTH-1 and increments row. At (HEIGHT-1, WIDTH-1) both wrap to 0.
- valid_out_buf: registered. It is 1 in the cycle after a pixel is accepted at position (row, col) with row>=K-1 and col>=K-1; otherwise it is 0.
  - It is a single-cycle strobe per window and is never held high across a valid_in=0 cycle.
  - It drops to 0 for col<K-1 on every row, which suppresses windows that wrap across a line edge.
  - Count: (HEIGHT-K+1)*(WIDTH-K+1) = 64 strobes per frame.
- Latency: 1 clk from acceptance of the completing pixel to valid_out_buf=1.
- frame_done: registered. It is 1 in the cycle after the pixel at (HEIGHT-1, WIDTH-1) is accepted, and coincides with the final valid_out_buf.
- Back-to-back frames: no flush is needed. The first window of a new frame, at (K-1, K-1), reads only new-frame taps. Stale data in sr is never exposed while valid_out_buf=1.
- Flow control: none. The consumer is always ready, and the upstream may insert bubbles freely.
- Reset mid-frame: everything clears immediately and asynchronously. The next accepted pixel is treated as (0,0).
- Signed data passes through bit-exact, with no saturation or extension.

Decomposition:
- A shared package holds the DW and K defaults and a localparam for the window element count (K*K).
- One sub-module is natural: win_shift_line (parameters WIDTH, K, DW; shift register plus tap mapping for a single channel), instantiated 3 times.
- Counters and valid/frame_done logic live in the top.

Test Plan:
1. Ramp frame, 144 pixels, valid_in held high; ch1 = row*12+col, ch2 = -(row*12+col), ch3 = row*12+col+100.
   - First valid_out_buf occurs 1 clk after pixel 52 is accepted.
   - win1 element 0 = 0, element 4 = 4, element 5 = 12, element 24 = 52; win2 element 24 = -52; win3 element 0 = 100.
   - Exactly 64 strobes are produced, plus one frame_done on the last.
2. Line-edge check: pixels at row 5, col 0..3 produce no strobe. Pixel (5,4) produces a window with element 0 = 12 and element 24 = 64.
3. Bubbles: same ramp with valid_in toggling 1/0.
   - Window contents match scenario 1.
   - The strobe is never asserted in a cycle following valid_in=0.
   - 64 strobes are produced.
4. Two back-to-back frames; the second uses ramp+1000. The first window of frame 2 has element 0 = 1000 and element 24 = 1052, with no frame-1 values.
5. Assert rst_n low asynchronously mid-cycle at pixel 70.
   - valid_out_buf, frame_done and win1..3 are 0 immediately.
   - A fresh ramp frame then reproduces scenario 1 exactly.
6. Extremes: ch1 all -2048 and ch2 all 2047. Every window element equals -2048 and 2047 respectively, bit-exact.
